// File: rtl/sdhci_cmd_seq.sv
// -----------------------------------------------------------------------------
// sdhci_cmd_seq
//
// Hardware command sequencer: issues a single SD command through the SDHCI
// register file as an OBI manager, with no CPU involvement.
//
// Flow: wait for Present State CMD inhibit to clear (0x24), write Argument
// (0x08), write Command (upper half of 0x0C), poll Normal/Error Interrupt
// Status (0x30) for command complete or error, W1C-clear the observed status,
// read the response words (0x10..0x1C), then present the result.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   cmd_valid_i/ready_o    command descriptor handshake
//   cmd_index_i            SD command index
//   cmd_arg_i              32-bit argument
//   cmd_resp_type_i        00 none, 01 R136, 10 R48, 11 R48-busy
//   cmd_crc_chk_i          Command register bit 3
//   cmd_idx_chk_i          Command register bit 4
//   cmd_data_i             Command register bit 5
//   rsp_valid_o/ready_i    result handshake
//   rsp_data_o             response words, RESP0 in [31:0]
//   rsp_err_status_o       captured Error Interrupt Status
//   rsp_err_o              error interrupt seen in status
//   rsp_timeout_o          a poll phase hit PollLimit reads
//   rsp_bus_err_o          an OBI access returned err
//   busy_o                 high whenever not idle
//   obi_req_o / obi_rsp_i  OBI manager port (one outstanding access)
// -----------------------------------------------------------------------------

package sdhci_cmd_seq_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        rid;
    } obi_rsp_t;

endpackage

module sdhci_cmd_seq #(
    parameter type         obi_req_t = sdhci_cmd_seq_pkg::obi_req_t,
    parameter type         obi_rsp_t = sdhci_cmd_seq_pkg::obi_rsp_t,
    parameter logic [31:0] BaseAddr  = 32'h0000_0000,
    parameter int unsigned PollLimit = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic [5:0]     cmd_index_i,
    input  logic [31:0]    cmd_arg_i,
    input  logic [1:0]     cmd_resp_type_i,
    input  logic           cmd_crc_chk_i,
    input  logic           cmd_idx_chk_i,
    input  logic           cmd_data_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [127:0]   rsp_data_o,
    output logic [15:0]    rsp_err_status_o,
    output logic           rsp_err_o,
    output logic           rsp_timeout_o,
    output logic           rsp_bus_err_o,
    output logic           busy_o,
    output obi_req_t       obi_req_o,
    input  obi_rsp_t       obi_rsp_i
);

    localparam int unsigned     CntW    = $clog2(PollLimit + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(PollLimit - 1);
    localparam logic            ObiId   = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_ARG     = 3'd2,
        S_CMD     = 3'd3,
        S_STATUS  = 3'd4,
        S_CLEAR   = 3'd5,
        S_RESP    = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    // Upper half of the Command register; command type is always "normal".
    function automatic logic [15:0] cmd_word(input logic [5:0] idx,
                                             input logic       dat,
                                             input logic       ichk,
                                             input logic       crc,
                                             input logic [1:0] rt);
        return {2'b00, idx, 2'b00, dat, ichk, crc, 1'b0, rt};
    endfunction

    state_e          state_q, state_d;
    logic            pend_q, pend_d;
    logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
    logic [1:0]      word_q, word_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     arg_q, arg_d;
    logic [1:0]      rtype_q, rtype_d;
    logic            crc_q, crc_d;
    logic            ichk_q, ichk_d;
    logic            dat_q, dat_d;
    logic [31:0]     status_q, status_d;
    logic [127:0]    rsp_data_q, rsp_data_d;
    logic [15:0]     err_status_q, err_status_d;
    logic            err_q, err_d;
    logic            timeout_q, timeout_d;
    logic            bus_err_q, bus_err_d;

    logic            access_s;
    logic            grant_s;
    logic            rd_done_s;
    logic            rd_ok_s;
    logic            rd_err_s;
    logic [31:0]     rdata_s;

    assign access_s  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign grant_s   = obi_req_o.req & obi_rsp_i.gnt;
    // Only a response to our own outstanding access counts; anything else
    // (e.g. a late rvalid after reset) is dropped.
    assign rd_done_s = pend_q & obi_rsp_i.rvalid & (obi_rsp_i.rid == ObiId);
    assign rd_ok_s   = rd_done_s & ~obi_rsp_i.err;
    assign rd_err_s  = rd_done_s & obi_rsp_i.err;
    assign rdata_s   = obi_rsp_i.rdata;

    assign cmd_ready_o      = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign rsp_valid_o      = (state_q == S_DONE);
    assign rsp_data_o       = rsp_data_q;
    assign rsp_err_status_o = err_status_q;
    assign rsp_err_o        = err_q;
    assign rsp_timeout_o    = timeout_q;
    assign rsp_bus_err_o    = bus_err_q;

    // OBI request: address/data are pure functions of held state, so they stay
    // stable while req waits for gnt; req drops once the access is granted.
    always_comb begin
        obi_req_o       = '0;
        obi_req_o.req   = access_s & ~pend_q;
        obi_req_o.aid   = ObiId;
        obi_req_o.be    = 4'hF;
        obi_req_o.addr  = BaseAddr;
        case (state_q)
            S_INHIBIT: obi_req_o.addr = BaseAddr + 32'h0000_0024;
            S_ARG: begin
                obi_req_o.addr  = BaseAddr + 32'h0000_0008;
                obi_req_o.we    = 1'b1;
                obi_req_o.wdata = arg_q;
            end
            S_CMD: begin
                obi_req_o.addr  = BaseAddr + 32'h0000_000C;
                obi_req_o.we    = 1'b1;
                obi_req_o.be    = 4'b1100;
                obi_req_o.wdata = {cmd_word(idx_q, dat_q, ichk_q, crc_q, rtype_q), 16'h0000};
            end
            S_STATUS:  obi_req_o.addr = BaseAddr + 32'h0000_0030;
            S_CLEAR: begin
                obi_req_o.addr  = BaseAddr + 32'h0000_0030;
                obi_req_o.we    = 1'b1;
                obi_req_o.wdata = status_q;
            end
            S_RESP:    obi_req_o.addr = BaseAddr + 32'h0000_0010 + {28'h000_0000, word_q, 2'b00};
            default:   obi_req_o.be   = 4'h0;
        endcase
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d      = state_q;
        poll_cnt_d   = poll_cnt_q;
        word_d       = word_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        rtype_d      = rtype_q;
        crc_d        = crc_q;
        ichk_d       = ichk_q;
        dat_d        = dat_q;
        status_d     = status_q;
        rsp_data_d   = rsp_data_q;
        err_status_d = err_status_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        bus_err_d    = bus_err_q;

        if (grant_s) begin
            pend_d = 1'b1;
        end else if (rd_done_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    idx_d        = cmd_index_i;
                    arg_d        = cmd_arg_i;
                    rtype_d      = cmd_resp_type_i;
                    crc_d        = cmd_crc_chk_i;
                    ichk_d       = cmd_idx_chk_i;
                    dat_d        = cmd_data_i;
                    rsp_data_d   = 128'h0;
                    err_status_d = 16'h0000;
                    err_d        = 1'b0;
                    timeout_d    = 1'b0;
                    bus_err_d    = 1'b0;
                    poll_cnt_d   = '0;
                    state_d      = S_INHIBIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INHIBIT: begin
                if (rd_ok_s) begin
                    poll_cnt_d = poll_cnt_q + CntW'(1);
                    if (!rdata_s[0]) begin
                        state_d = S_ARG;
                    end else if (poll_cnt_q == CntLast) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_INHIBIT;
                    end
                end else begin
                    state_d = S_INHIBIT;
                end
            end
            S_ARG: begin
                if (rd_ok_s) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_ARG;
                end
            end
            S_CMD: begin
                if (rd_ok_s) begin
                    poll_cnt_d = '0;
                    state_d    = S_STATUS;
                end else begin
                    state_d = S_CMD;
                end
            end
            S_STATUS: begin
                if (rd_ok_s) begin
                    poll_cnt_d = poll_cnt_q + CntW'(1);
                    if (rdata_s[0] || rdata_s[15]) begin
                        status_d     = rdata_s;
                        err_status_d = rdata_s[31:16];
                        err_d        = rdata_s[15];
                        state_d      = S_CLEAR;
                    end else if (poll_cnt_q == CntLast) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_STATUS;
                    end
                end else begin
                    state_d = S_STATUS;
                end
            end
            S_CLEAR: begin
                if (rd_ok_s) begin
                    word_d = 2'd0;
                    if ((rtype_q == 2'b00) || err_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_RESP: begin
                if (rd_ok_s) begin
                    rsp_data_d[{word_q, 5'b00000} +: 32] = rdata_s;
                    if ((rtype_q == 2'b01) && (word_q != 2'd3)) begin
                        word_d  = word_q + 2'd1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A bus error on any access ends the command immediately.
        if (rd_err_s) begin
            bus_err_d = 1'b1;
            state_d   = S_DONE;
        end else begin
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            poll_cnt_q   <= '0;
            word_q       <= 2'd0;
            idx_q        <= 6'd0;
            arg_q        <= 32'h0;
            rtype_q      <= 2'b00;
            crc_q        <= 1'b0;
            ichk_q       <= 1'b0;
            dat_q        <= 1'b0;
            status_q     <= 32'h0;
            rsp_data_q   <= 128'h0;
            err_status_q <= 16'h0000;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            poll_cnt_q   <= poll_cnt_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            rtype_q      <= rtype_d;
            crc_q        <= crc_d;
            ichk_q       <= ichk_d;
            dat_q        <= dat_d;
            status_q     <= status_d;
            rsp_data_q   <= rsp_data_d;
            err_status_q <= err_status_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            bus_err_q    <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_sdhci_cmd_seq.sv
// Testbench for sdhci_cmd_seq: scripted OBI subordinate, access scoreboard,
// response scoreboard with a decoupled monitor.
module tb_sdhci_cmd_seq;
    import sdhci_cmd_seq_pkg::*;

    localparam logic [31:0] BA = 32'h4000_0100;
    localparam int unsigned PL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   cmd_rt;
    logic         cmd_crc, cmd_ichk, cmd_dat;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
    logic [15:0]  rsp_err_status;
    logic         rsp_err, rsp_timeout, rsp_bus_err, busy;
    obi_req_t     obi_req;
    obi_rsp_t     obi_rsp;

    always #5 clk = ~clk;

    sdhci_cmd_seq #(.BaseAddr(BA), .PollLimit(PL)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg), .cmd_resp_type_i(cmd_rt),
        .cmd_crc_chk_i(cmd_crc), .cmd_idx_chk_i(cmd_ichk), .cmd_data_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_status_o(rsp_err_status),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .rsp_bus_err_o(rsp_bus_err),
        .busy_o(busy), .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  es;
        logic [2:0]   flags;  // {err, timeout, bus_err}
        int           lat;    // cycles handshake->rsp_valid, -1 = unchecked
    } exp_t;

    acc_t bus_q[$];
    exp_t rsp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   n_rsp = 0;

    // subordinate script
    int          inhibit_left = 0;
    int          status_left = 0;
    logic [31:0] status_val = 32'h0000_0001;
    logic [31:0] resp_w [4];
    bit          rand_mode = 0;
    bit          hang_status = 0;
    bit          status_granted = 0;
    bit          err_en = 0;
    logic [31:0] err_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_acc(input logic [31:0] off, input logic we, input logic [3:0] be, input logic [31:0] wd);
        acc_t x;
        x.addr = BA + off; x.we = we; x.be = be; x.wdata = wd;
        bus_q.push_back(x);
    endtask

    task automatic exp_rsp(input logic [127:0] d, input logic [15:0] es, input logic [2:0] fl, input int lat);
        exp_t e;
        e.data = d; e.es = es; e.flags = fl; e.lat = lat;
        rsp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_obi_req"}, obi_req.req, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, 128'h0);
        check({tag, "_flags"}, {rsp_err_status, rsp_err, rsp_timeout, rsp_bus_err}, 19'h0);
    endtask

    task automatic issue_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                             input logic crc, input logic ichk, input logic dat);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg; cmd_rt = rt;
        cmd_crc = crc; cmd_ichk = ichk; cmd_dat = dat;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready", cmd_ready, 1'b1);
        hs_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic crc, input logic ichk, input logic dat);
        int target;
        int t;
        target = n_rsp + 1;
        issue_cmd(idx, arg, rt, crc, ichk, dat);
        t = 0;
        while (n_rsp < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_arrived", n_rsp >= target, 1'b1);
        check("accesses_left", bus_q.size(), 0);
    endtask

    // OBI subordinate: scripted read data, optional random gnt/rvalid delays.
    initial begin
        acc_t        a;
        acc_t        x;
        int          gd;
        int          rd;
        logic [31:0] off;
        logic [31:0] rdv;
        obi_rsp = '0;
        forever begin
            @(negedge clk);
            obi_rsp.rvalid = 1'b0;
            obi_rsp.err    = 1'b0;
            obi_rsp.rdata  = 32'h0;
            if (obi_req.req && !rst) begin
                a.addr = obi_req.addr; a.we = obi_req.we; a.be = obi_req.be; a.wdata = obi_req.wdata;
                gd = rand_mode ? $urandom_range(0, 5) : 0;
                for (int i = 0; i < gd; i++) begin
                    @(negedge clk);
                    check("req_stable", {obi_req.req, obi_req.addr, obi_req.we, obi_req.be, obi_req.wdata},
                          {1'b1, a.addr, a.we, a.be, a.wdata});
                end
                obi_rsp.gnt = 1'b1;
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_access: got addr %0h we %0b wdata %0h, expected no access", a.addr, a.we, a.wdata);
                end else begin
                    x = bus_q.pop_front();
                    check("bus_access", a, x);
                end
                off = a.addr - BA;
                rdv = 32'h0;
                if (!a.we) begin
                    case (off)
                        32'h24: begin
                            if (inhibit_left > 0) begin inhibit_left--; rdv = 32'h0000_0001; end
                            else rdv = 32'hFFFF_FFFE;
                        end
                        32'h30: begin
                            if (status_left > 0) begin status_left--; rdv = 32'h0000_7FFE; end
                            else rdv = status_val;
                        end
                        32'h10, 32'h14, 32'h18, 32'h1C: rdv = resp_w[off[3:2]];
                        default: rdv = 32'hDEAD_BEEF;
                    endcase
                end
                if (hang_status && off == 32'h30) begin
                    hang_status = 0;
                    status_granted = 1;
                    rd = 6;
                end else begin
                    rd = rand_mode ? $urandom_range(0, 5) : 0;
                end
                @(negedge clk);
                obi_rsp.gnt = 1'b0;
                check("req_drop_after_gnt", obi_req.req, 1'b0);
                repeat (rd) @(negedge clk);
                obi_rsp.rvalid = 1'b1;
                obi_rsp.rdata  = rdv;
                obi_rsp.err    = err_en && (a.addr == err_addr);
            end
        end
    end

    // Response monitor: compare on first rsp_valid cycle, hold ready low one
    // cycle and check the result stays put, then accept.
    initial begin
        exp_t cur;
        bit   seen;
        seen = 0;
        rsp_ready = 1'b0;
        cur.data = 128'h0; cur.es = 16'h0; cur.flags = 3'b000; cur.lat = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    rsp_ready = 1'b0;
                    if (rsp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_rsp: got rsp_valid, expected no response");
                    end else begin
                        cur = rsp_q.pop_front();
                        check("rsp_data", rsp_data, cur.data);
                        check("rsp_err_status", rsp_err_status, cur.es);
                        check("rsp_flags", {rsp_err, rsp_timeout, rsp_bus_err}, cur.flags);
                        if (cur.lat >= 0) check("rsp_latency", cyc - hs_cyc, cur.lat);
                    end
                    n_rsp++;
                end else begin
                    check("rsp_hold_data", rsp_data, cur.data);
                    check("rsp_hold_flags", {rsp_err, rsp_timeout, rsp_bus_err}, cur.flags);
                    rsp_ready = 1'b1;
                end
            end else begin
                seen = 0;
                rsp_ready = 1'b0;
            end
        end
    end

    initial begin
        int t;
        int saved;
        rst = 1'b1; cmd_valid = 1'b0; cmd_index = 6'd0; cmd_arg = 32'h0; cmd_rt = 2'b00;
        cmd_crc = 1'b0; cmd_ichk = 1'b0; cmd_dat = 1'b0;
        for (int i = 0; i < 4; i++) resp_w[i] = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // CMD0, no response
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h0000_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_rsp(128'h0, 16'h0, 3'b000, 11);
        run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);

        // CMD8 R48 with crc+idx check
        resp_w[0] = 32'h0000_01AA;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_01AA);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h081A_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_acc(32'h10, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h1AA, 16'h0, 3'b000, 13);
        run_cmd(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b1, 1'b0);

        // CMD2 R136, two busy inhibit reads, one pending status read
        resp_w[0] = 32'h1111_1111; resp_w[1] = 32'h2222_2222;
        resp_w[2] = 32'h3333_3333; resp_w[3] = 32'h4444_4444;
        inhibit_left = 2; status_left = 1;
        repeat (3) exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h0209_0000);
        repeat (2) exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_acc(32'h10, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h14, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h18, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h1C, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h44444444_33333333_22222222_11111111, 16'h0, 3'b000, 25);
        run_cmd(6'd2, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0);

        // Error interrupt: no response reads, data zeroed from previous command
        status_val = 32'h0001_8001;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_1234);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h111A_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0001_8001);
        exp_rsp(128'h0, 16'h0001, 3'b100, 11);
        run_cmd(6'd17, 32'h0000_1234, 2'b10, 1'b1, 1'b1, 1'b0);
        status_val = 32'h0000_0001;

        // Inhibit stuck: exactly PL reads, then timeout
        inhibit_left = 1000;
        repeat (PL) exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h0, 16'h0, 3'b010, 9);
        run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        inhibit_left = 0;

        // Bus error on the Argument write
        err_en = 1; err_addr = BA + 32'h08;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_CAFE);
        exp_rsp(128'h0, 16'h0, 3'b001, 5);
        run_cmd(6'd55, 32'h0000_CAFE, 2'b10, 1'b0, 1'b0, 1'b0);
        err_en = 0;

        // Random gnt/rvalid delays
        rand_mode = 1;
        resp_w[0] = 32'h0000_01AA;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_01AA);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h081A_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_acc(32'h10, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h1AA, 16'h0, 3'b000, -1);
        run_cmd(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b1, 1'b0);

        resp_w[0] = 32'hAAAA_0000; resp_w[1] = 32'hBBBB_1111;
        resp_w[2] = 32'hCCCC_2222; resp_w[3] = 32'hDDDD_3333;
        inhibit_left = 1; status_left = 2;
        repeat (2) exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h0209_0000);
        repeat (3) exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_acc(32'h10, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h14, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h18, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h1C, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'hDDDD3333_CCCC2222_BBBB1111_AAAA0000, 16'h0, 3'b000, -1);
        run_cmd(6'd2, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0);

        // Reset while a status read is outstanding, stale rvalid afterwards
        hang_status = 1; status_granted = 0;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_0100);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h081A_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h0, 16'h0, 3'b000, -1);
        issue_cmd(6'd8, 32'h0000_0100, 2'b10, 1'b1, 1'b1, 1'b0);
        t = 0;
        while (!status_granted && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("status_granted", status_granted, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        check_idle("mid_reset");
        saved = n_rsp;
        repeat (10) @(negedge clk);
        check("no_rsp_after_stale_rvalid", n_rsp, saved);
        check_idle("after_stale");

        // Next command completes normally
        rand_mode = 0;
        resp_w[0] = 32'h0000_0900;
        exp_acc(32'h24, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h08, 1'b1, 4'hF, 32'h0000_0200);
        exp_acc(32'h0C, 1'b1, 4'b1100, 32'h111A_0000);
        exp_acc(32'h30, 1'b0, 4'hF, 32'h0);
        exp_acc(32'h30, 1'b1, 4'hF, 32'h0000_0001);
        exp_acc(32'h10, 1'b0, 4'hF, 32'h0);
        exp_rsp(128'h900, 16'h0, 3'b000, 13);
        run_cmd(6'd17, 32'h0000_0200, 2'b10, 1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("rsp_queue_left", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
